// File: rtl/amo_sequencer.sv
// Per-port atomic sequencer: runs one LR, SC or RMW request through memory and the atomic unit.
// Latency: LR 3, RMW 5, SC 3 (success) / 2 (fail); error requests respond after 1 cycle.
module amo_sequencer #(
  parameter int AMO_OP_W = 5,
  parameter int ID_W     = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [1:0]          req_type,
  input  logic [AMO_OP_W-1:0] req_op,
  input  logic [31:0]         req_addr,
  input  logic [31:0]         req_data,
  input  logic [ID_W-1:0]     req_id,
  output logic                mem_valid,
  input  logic                mem_ready,
  output logic                mem_we,
  output logic [31:0]         mem_addr,
  output logic [31:0]         mem_wdata,
  input  logic                mem_rvalid,
  input  logic [31:0]         mem_rdata,
  output logic                set_reservation,
  output logic                clear_reservation,
  output logic [31:0]         reservation,
  input  logic                reservation_valid,
  output logic                rmw_valid,
  output logic [AMO_OP_W-1:0] op,
  output logic [31:0]         rs1,
  output logic [31:0]         rs2,
  input  logic [31:0]         rd,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [31:0]         rsp_data,
  output logic                rsp_err,
  output logic [ID_W-1:0]     rsp_id
);

  typedef enum logic [2:0] {
    IDLE, RD_REQ, RD_WAIT, ALU, SC_CHK, WR_REQ, RSP
  } state_e;

  localparam logic [1:0] T_LR  = 2'd0;
  localparam logic [1:0] T_SC  = 2'd1;
  localparam logic [1:0] T_RMW = 2'd2;
  localparam logic [1:0] T_RSV = 2'd3;

  state_e              state_q, state_d;
  logic [1:0]          type_q, type_d;
  logic [AMO_OP_W-1:0] op_q, op_d;
  logic [31:0]         addr_q, addr_d;
  logic [31:0]         data_q, data_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [31:0]         load_q, load_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         rsp_data_q, rsp_data_d;
  logic                rsp_err_q, rsp_err_d;

  // Everything visible on the ports is reset so the block is quiet during reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      type_q     <= T_LR;
      op_q       <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      id_q       <= '0;
      load_q     <= '0;
      wdata_q    <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      type_q     <= type_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      id_q       <= id_d;
      load_q     <= load_d;
      wdata_q    <= wdata_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  always_comb begin
    state_d           = state_q;
    type_d            = type_q;
    op_d              = op_q;
    addr_d            = addr_q;
    data_d            = data_q;
    id_d              = id_q;
    load_d            = load_q;
    wdata_d           = wdata_q;
    rsp_data_d        = rsp_data_q;
    rsp_err_d         = rsp_err_q;
    req_ready         = 1'b0;
    mem_valid         = 1'b0;
    mem_we            = 1'b0;
    set_reservation   = 1'b0;
    clear_reservation = 1'b0;
    rmw_valid         = 1'b0;
    rsp_valid         = 1'b0;

    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          type_d    = req_type;
          op_d      = req_op;
          addr_d    = req_addr;
          data_d    = req_data;
          id_d      = req_id;
          rsp_err_d = 1'b0;
          if (req_addr[1:0] != 2'b00 || req_type == T_RSV) begin
            rsp_err_d  = 1'b1;
            rsp_data_d = '0;
            state_d    = RSP;
          end else if (req_type == T_SC) begin
            state_d = SC_CHK;
          end else begin
            state_d = RD_REQ;
          end
        end
      end
      RD_REQ: begin
        mem_valid = 1'b1;
        if (mem_ready) state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (mem_rvalid) begin
          load_d = mem_rdata;
          if (type_q == T_LR) begin
            set_reservation = 1'b1;
            rsp_data_d      = mem_rdata;
            state_d         = RSP;
          end else begin
            state_d = ALU;
          end
        end
      end
      ALU: begin
        rmw_valid = 1'b1;
        wdata_d   = rd;
        state_d   = WR_REQ;
      end
      SC_CHK: begin
        // SC always consumes the reservation, whether or not it stores.
        clear_reservation = 1'b1;
        if (reservation_valid) begin
          wdata_d    = data_q;
          rsp_data_d = '0;
          state_d    = WR_REQ;
        end else begin
          rsp_data_d = 32'd1;
          state_d    = RSP;
        end
      end
      WR_REQ: begin
        mem_valid = 1'b1;
        mem_we    = 1'b1;
        if (mem_ready) begin
          if (type_q == T_RMW) begin
            clear_reservation = 1'b1;
            rsp_data_d        = load_q;
          end
          state_d = RSP;
        end
      end
      RSP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign reservation = addr_q;
  assign op          = op_q;
  assign rs1         = load_q;
  assign rs2         = data_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_id      = id_q;

endmodule

// File: tb/tb_amo_sequencer.sv
// Directed bench for amo_sequencer: a stallable memory model, a per-cycle monitor and one task per scenario.
module tb_amo_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_type = 2'd0;
  logic [4:0]  req_op = 5'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_data = 32'd0;
  logic [3:0]  req_id = 4'd0;
  logic        mem_valid, mem_we;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata;
  logic        set_reservation, clear_reservation, rmw_valid;
  logic [31:0] reservation;
  logic        reservation_valid = 1'b0;
  logic [4:0]  op;
  logic [31:0] rs1, rs2, rd;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic [3:0]  rsp_id;

  int checks = 0;
  int failures = 0;

  logic [31:0] mem_word = 32'd0;
  int stall_rd = 0, stall_wr = 0, rv_delay = 0;

  int rd_cnt = 0, wr_cnt = 0, mv_cnt = 0, set_cnt = 0, clr_cnt = 0, clr_wr_cnt = 0, rmw_cnt = 0;
  int overlap_err = 0, stab_err = 0, rdy_err = 0;
  logic [31:0] wr_addr = 0, wr_data = 0, set_addr = 0, rmw_rs1 = 0, rmw_rs2 = 0;

  assign mem_rdata = mem_word;
  assign rd = rs1 + rs2;

  always #5 clk = ~clk;

  amo_sequencer #(.AMO_OP_W(5), .ID_W(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_type(req_type), .req_op(req_op),
    .req_addr(req_addr), .req_data(req_data), .req_id(req_id),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .set_reservation(set_reservation), .clear_reservation(clear_reservation),
    .reservation(reservation), .reservation_valid(reservation_valid),
    .rmw_valid(rmw_valid), .op(op), .rs1(rs1), .rs2(rs2), .rd(rd),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .rsp_id(rsp_id)
  );

  // Memory model drives at negedge; the monitor samples 2ns later, well before the next posedge.
  logic hs = 0, hs_we = 0, in_txn = 0;
  int pend_cnt = 0, stall_left = 0;
  logic p_mem = 0, p_we = 0, p_rsp = 0, p_err = 0;
  logic [31:0] p_addr = 0, p_wd = 0, p_rd = 0;
  logic [3:0] p_id = 0;

  always @(negedge clk) begin
    if (rst) begin
      pend_cnt = 0; in_txn = 0; stall_left = 0; mem_ready = 0; mem_rvalid = 0;
    end else begin
      if (hs) begin
        in_txn = 0;
        if (!hs_we) pend_cnt = rv_delay + 1;
      end
      mem_rvalid = 0;
      if (pend_cnt > 0) begin
        pend_cnt--;
        if (pend_cnt == 0) mem_rvalid = 1;
      end
      if (mem_valid) begin
        if (!in_txn) begin
          in_txn = 1;
          stall_left = mem_we ? stall_wr : stall_rd;
        end
        if (stall_left > 0) begin mem_ready = 0; stall_left--; end
        else mem_ready = 1;
      end else begin
        mem_ready = 0;
      end
    end
    #2;
    if (rst) begin
      hs = 0; p_mem = 0; p_rsp = 0;
    end else begin
      hs = mem_valid && mem_ready;
      hs_we = mem_we;
      if (hs && mem_we) begin wr_cnt++; wr_addr = mem_addr; wr_data = mem_wdata; end
      if (hs && !mem_we) rd_cnt++;
      if (mem_valid) mv_cnt++;
      if (set_reservation) begin set_cnt++; set_addr = reservation; end
      if (clear_reservation) begin clr_cnt++; if (hs && mem_we) clr_wr_cnt++; end
      if (rmw_valid) begin rmw_cnt++; rmw_rs1 = rs1; rmw_rs2 = rs2; end
      if (int'(set_reservation) + int'(clear_reservation) + int'(rmw_valid) > 1) overlap_err++;
      if (p_mem && (!mem_valid || mem_we !== p_we || mem_addr !== p_addr || mem_wdata !== p_wd)) stab_err++;
      if (p_rsp && (!rsp_valid || rsp_data !== p_rd || rsp_err !== p_err || rsp_id !== p_id)) stab_err++;
      if (req_ready && (mem_valid || rsp_valid)) rdy_err++;
      p_mem = mem_valid && !mem_ready; p_we = mem_we; p_addr = mem_addr; p_wd = mem_wdata;
      p_rsp = rsp_valid && !rsp_ready; p_rd = rsp_data; p_err = rsp_err; p_id = rsp_id;
    end
  end

  // Issues one request from posedge+1 and returns the response; lat counts cycles after the accept cycle.
  task automatic do_req(input logic [1:0] t, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] id, input int hold,
                        output int lat, output logic [31:0] rdat, output logic rerr, output logic [3:0] rid);
    req_valid = 1; req_type = t; req_op = 5'd0; req_addr = a; req_data = d; req_id = id;
    @(posedge clk); #1;
    req_valid = 0;
    lat = 1;
    while (!rsp_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    rdat = rsp_data; rerr = rsp_err; rid = rsp_id;
    repeat (hold) begin @(posedge clk); #1; end
    rsp_ready = 1;
    @(posedge clk); #1;
    rsp_ready = 0;
  endtask

  int lat;
  logic [31:0] rdat;
  logic rerr;
  logic [3:0] rid;
  int b_rd, b_wr, b_mv, b_set, b_clr, b_clrwr, b_rmw, b_stab, b_rdy, b_ovl;

  task automatic snap();
    b_rd = rd_cnt; b_wr = wr_cnt; b_mv = mv_cnt; b_set = set_cnt; b_clr = clr_cnt;
    b_clrwr = clr_wr_cnt; b_rmw = rmw_cnt; b_stab = stab_err; b_rdy = rdy_err; b_ovl = overlap_err;
  endtask

  task automatic test_reset();
    #1 rst = 1;
    #2;
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
    checks++; if ({mem_valid, mem_we, set_reservation, clear_reservation, rmw_valid, rsp_valid, rsp_err} !== 7'd0) begin
      failures++; $display("FAIL reset_ctrl got %b want 0000000", {mem_valid, mem_we, set_reservation, clear_reservation, rmw_valid, rsp_valid, rsp_err}); end
    checks++; if ({mem_addr, mem_wdata, reservation, rs1, rs2, rsp_data} !== 192'd0) begin
      failures++; $display("FAIL reset_data got %h want 0", {mem_addr, mem_wdata, reservation, rs1, rs2, rsp_data}); end
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_lr();
    snap(); mem_word = 32'hDEADBEEF;
    do_req(2'd0, 32'h1000, 32'h0, 4'd3, 0, lat, rdat, rerr, rid);
    checks++; if (lat !== 3) begin failures++; $display("FAIL lr_latency got %0d want 3", lat); end
    checks++; if (rdat !== 32'hDEADBEEF) begin failures++; $display("FAIL lr_data got %h want deadbeef", rdat); end
    checks++; if ({rerr, rid} !== {1'b0, 4'd3}) begin failures++; $display("FAIL lr_err_id got %b/%0d want 0/3", rerr, rid); end
    checks++; if (set_cnt - b_set !== 1 || set_addr !== 32'h1000) begin
      failures++; $display("FAIL lr_set got %0d@%h want 1@1000", set_cnt - b_set, set_addr); end
    checks++; if (rd_cnt - b_rd !== 1 || wr_cnt - b_wr !== 0 || clr_cnt - b_clr !== 0) begin
      failures++; $display("FAIL lr_mem got rd=%0d wr=%0d clr=%0d want 1/0/0", rd_cnt - b_rd, wr_cnt - b_wr, clr_cnt - b_clr); end
  endtask

  task automatic test_sc();
    snap(); reservation_valid = 1;
    do_req(2'd1, 32'h1000, 32'h55, 4'd5, 0, lat, rdat, rerr, rid);
    checks++; if (lat !== 3) begin failures++; $display("FAIL sc_ok_latency got %0d want 3", lat); end
    checks++; if (rdat !== 32'd0 || rerr !== 1'b0) begin failures++; $display("FAIL sc_ok_rsp got %h/%b want 0/0", rdat, rerr); end
    checks++; if (wr_cnt - b_wr !== 1 || wr_addr !== 32'h1000 || wr_data !== 32'h55) begin
      failures++; $display("FAIL sc_ok_write got n=%0d %h=%h want 1 1000=55", wr_cnt - b_wr, wr_addr, wr_data); end
    checks++; if (clr_cnt - b_clr !== 1 || rd_cnt - b_rd !== 0) begin
      failures++; $display("FAIL sc_ok_clr got clr=%0d rd=%0d want 1/0", clr_cnt - b_clr, rd_cnt - b_rd); end
    snap(); reservation_valid = 0;
    do_req(2'd1, 32'h1000, 32'h66, 4'd6, 0, lat, rdat, rerr, rid);
    checks++; if (lat !== 2) begin failures++; $display("FAIL sc_fail_latency got %0d want 2", lat); end
    checks++; if (rdat !== 32'd1 || rid !== 4'd6) begin failures++; $display("FAIL sc_fail_rsp got %h/%0d want 1/6", rdat, rid); end
    checks++; if (clr_cnt - b_clr !== 1 || mv_cnt - b_mv !== 0) begin
      failures++; $display("FAIL sc_fail_mem got clr=%0d memcyc=%0d want 1/0", clr_cnt - b_clr, mv_cnt - b_mv); end
  endtask

  task automatic test_rmw();
    snap(); mem_word = 32'd5;
    do_req(2'd2, 32'h2000, 32'd7, 4'd9, 0, lat, rdat, rerr, rid);
    checks++; if (lat !== 5) begin failures++; $display("FAIL rmw_latency got %0d want 5", lat); end
    checks++; if (rdat !== 32'd5 || rerr !== 1'b0) begin failures++; $display("FAIL rmw_rsp got %h/%b want 5/0", rdat, rerr); end
    checks++; if (rmw_cnt - b_rmw !== 1 || rmw_rs1 !== 32'd5 || rmw_rs2 !== 32'd7) begin
      failures++; $display("FAIL rmw_alu got n=%0d rs1=%h rs2=%h want 1/5/7", rmw_cnt - b_rmw, rmw_rs1, rmw_rs2); end
    checks++; if (wr_cnt - b_wr !== 1 || wr_addr !== 32'h2000 || wr_data !== 32'd12) begin
      failures++; $display("FAIL rmw_write got n=%0d %h=%h want 1 2000=c", wr_cnt - b_wr, wr_addr, wr_data); end
    checks++; if (clr_cnt - b_clr !== 1 || clr_wr_cnt - b_clrwr !== 1 || set_cnt - b_set !== 0) begin
      failures++; $display("FAIL rmw_resv got clr=%0d clr_on_wr=%0d set=%0d want 1/1/0", clr_cnt - b_clr, clr_wr_cnt - b_clrwr, set_cnt - b_set); end
  endtask

  task automatic test_backpressure();
    snap(); mem_word = 32'd5; stall_rd = 4; stall_wr = 4;
    do_req(2'd2, 32'h3000, 32'd7, 4'd2, 3, lat, rdat, rerr, rid);
    stall_rd = 0; stall_wr = 0;
    checks++; if (lat !== 13) begin failures++; $display("FAIL bp_latency got %0d want 13", lat); end
    checks++; if (stab_err - b_stab !== 0) begin failures++; $display("FAIL bp_stable got %0d unstable cycles want 0", stab_err - b_stab); end
    checks++; if (rdy_err - b_rdy !== 0) begin failures++; $display("FAIL bp_req_ready got %0d busy-ready cycles want 0", rdy_err - b_rdy); end
    checks++; if (rd_cnt - b_rd !== 1 || wr_cnt - b_wr !== 1 || wr_data !== 32'd12) begin
      failures++; $display("FAIL bp_mem got rd=%0d wr=%0d wdata=%h want 1/1/c", rd_cnt - b_rd, wr_cnt - b_wr, wr_data); end
    checks++; if (rdat !== 32'd5) begin failures++; $display("FAIL bp_rsp got %h want 5", rdat); end
    checks++; if (overlap_err !== 0) begin failures++; $display("FAIL pulse_overlap got %0d want 0", overlap_err); end
  endtask

  task automatic test_err();
    snap();
    do_req(2'd0, 32'h1002, 32'h0, 4'd7, 0, lat, rdat, rerr, rid);
    checks++; if (lat !== 1 || rerr !== 1'b1 || rdat !== 32'd0 || rid !== 4'd7) begin
      failures++; $display("FAIL err_misaligned got lat=%0d err=%b data=%h id=%0d want 1/1/0/7", lat, rerr, rdat, rid); end
    do_req(2'd3, 32'h1000, 32'h9, 4'd8, 0, lat, rdat, rerr, rid);
    checks++; if (lat !== 1 || rerr !== 1'b1 || rdat !== 32'd0) begin
      failures++; $display("FAIL err_type got lat=%0d err=%b data=%h want 1/1/0", lat, rerr, rdat); end
    checks++; if ((mv_cnt - b_mv) + (set_cnt - b_set) + (clr_cnt - b_clr) + (rmw_cnt - b_rmw) !== 0) begin
      failures++; $display("FAIL err_activity got %0d events want 0", (mv_cnt - b_mv) + (set_cnt - b_set) + (clr_cnt - b_clr) + (rmw_cnt - b_rmw)); end
  endtask

  task automatic test_async_reset();
    mem_word = 32'hCAFEF00D; rv_delay = 6;
    req_valid = 1; req_type = 2'd0; req_addr = 32'h4000; req_data = 0; req_id = 4'd1;
    @(posedge clk); #1; req_valid = 0;
    @(posedge clk); #1;
    checks++; if (reservation !== 32'h4000 || req_ready !== 1'b0) begin
      failures++; $display("FAIL arst_pre got resv=%h rdy=%b want 4000/0", reservation, req_ready); end
    #2 rst = 1;
    #1;
    checks++; if ({mem_valid, rsp_valid, set_reservation, clear_reservation, rmw_valid, req_ready} !== 6'b000001) begin
      failures++; $display("FAIL arst_ctrl got %b want 000001", {mem_valid, rsp_valid, set_reservation, clear_reservation, rmw_valid, req_ready}); end
    checks++; if ({reservation, rs1, rsp_data} !== 96'd0) begin
      failures++; $display("FAIL arst_data got %h want 0", {reservation, rs1, rsp_data}); end
    @(negedge clk) rst = 0;
    rv_delay = 0;
    @(posedge clk); #1;
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL arst_release got %b want 1", req_ready); end
    snap(); mem_word = 32'h12345678;
    do_req(2'd0, 32'h1000, 32'h0, 4'd4, 0, lat, rdat, rerr, rid);
    checks++; if (lat !== 3 || rdat !== 32'h12345678 || set_cnt - b_set !== 1) begin
      failures++; $display("FAIL arst_next_lr got lat=%0d data=%h set=%0d want 3/12345678/1", lat, rdat, set_cnt - b_set); end
  endtask

  initial begin
    test_reset();
    test_lr();
    test_sc();
    test_rmw();
    test_backpressure();
    test_err();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got no finish want finish");
    $fatal(1);
  end

endmodule
